// File: rtl/cmp_pkg.sv
// Shared comparator definitions: active-low result codes and sequencer state encoding.
package cmp_pkg;

    localparam logic [2:0] Y_EQ   = 3'b101;
    localparam logic [2:0] Y_GT   = 3'b011;
    localparam logic [2:0] Y_LT   = 3'b110;
    localparam logic [2:0] Y_NONE = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_mag_compare_digit_cmp.sv
// Combinational unsigned comparison of one DIGIT-bit slice of each operand.
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] da,
    input  logic [DIGIT-1:0] db,
    output logic             gt,
    output logic             lt
);

    assign gt = (da > db);
    assign lt = (da < db);

endmodule

// File: rtl/seq_mag_compare.sv
// Multi-cycle MSB-first magnitude comparator with early exit, signed/unsigned mode,
// start/busy/done handshake and synchronous abort.
module seq_mag_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [2:0]       y
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]    IDX_TOP   = IW'(N - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $fatal(1, "seq_mag_compare: WIDTH must be a multiple of DIGIT");
    end

    state_t           state, next_state;
    logic [WIDTH-1:0] ra, rb;
    logic [IW-1:0]    idx;
    logic [DIGIT-1:0] da, db;
    logic             gt, lt;
    logic             accept, decide, finish;

    assign da = ra[idx*DIGIT +: DIGIT];
    assign db = rb[idx*DIGIT +: DIGIT];

    digit_cmp #(.DIGIT(DIGIT)) u_digit (
        .da (da),
        .db (db),
        .gt (gt),
        .lt (lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start && !clr)    next_state = CMP;
            CMP:  if (clr || decide)    next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    // clr outranks both a fresh start in IDLE and a decision in CMP.
    always_comb begin
        busy   = (state == CMP);
        accept = (state == IDLE) && start && !clr;
        decide = (state == CMP) && (gt || lt || (idx == '0));
        finish = decide && !clr;
    end

    // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            idx  <= '0;
            done <= 1'b0;
            y    <= Y_NONE;
        end else begin
            done <= finish;
            if (accept) begin
                ra  <= signed_mode ? (a ^ SIGN_MASK) : a;
                rb  <= signed_mode ? (b ^ SIGN_MASK) : b;
                idx <= IDX_TOP;
            end else if (busy && !clr && !decide) begin
                idx <= idx - 1'b1;
            end
            if (finish) begin
                if (gt)      y <= Y_GT;
                else if (lt) y <= Y_LT;
                else         y <= Y_EQ;
            end
        end
    end

endmodule

// File: tb/tb_seq_mag_compare.sv
// Directed and randomized checks of seq_mag_compare at DIGIT=4, 16 and 1 against a
// prefix-based reference model of result and latency.
module tb_seq_mag_compare;
    import cmp_pkg::*;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        mode = 1'b0;
    logic [15:0] a    = '0;
    logic [15:0] b    = '0;
    logic [2:0]  start_v = '0;
    logic [2:0]  clr_v   = '0;
    logic [2:0]  busy_v, done_v;
    logic [2:0]  y0, y1, y2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mag_compare #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(mode), .clr(clr_v[0]),
        .a(a), .b(b), .busy(busy_v[0]), .done(done_v[0]), .y(y0));

    seq_mag_compare #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(mode), .clr(clr_v[1]),
        .a(a), .b(b), .busy(busy_v[1]), .done(done_v[1]), .y(y1));

    seq_mag_compare #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(mode), .clr(clr_v[2]),
        .a(a), .b(b), .busy(busy_v[2]), .done(done_v[2]), .y(y2));

    function automatic int digit_of(input int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 16 : 1;
    endfunction

    function automatic logic [2:0] y_of(input int sel);
        return (sel == 0) ? y0 : (sel == 1) ? y1 : y2;
    endfunction

    function automatic logic [2:0] model_y(input logic [15:0] ma, input logic [15:0] mb,
                                           input logic m);
        int sa, sb;
        sa = m ? int'($signed(ma)) : int'(ma);
        sb = m ? int'($signed(mb)) : int'(mb);
        if (sa > sb)      return 3'b011;
        else if (sa < sb) return 3'b110;
        else              return 3'b101;
    endfunction

    // Latency is the number of leading digits needed before the top bits first disagree.
    function automatic int model_lat(input logic [15:0] ma, input logic [15:0] mb,
                                     input int d);
        int n;
        n = 16 / d;
        for (int i = 1; i <= n; i++) begin
            if ((ma >> (16 - i * d)) != (mb >> (16 - i * d))) return i;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmp(input string tag, input int sel, input logic [15:0] ta,
                          input logic [15:0] tb, input logic m);
        int lat;
        bit got;
        @(negedge clk);
        a = ta;
        b = tb;
        mode = m;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1 start_v[sel] = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (done_v[sel]) got = 1'b1;
        end
        check({tag, "_lat"}, lat, model_lat(ta, tb, digit_of(sel)));
        check({tag, "_y"}, y_of(sel), model_y(ta, tb, m));
    endtask

    initial begin
        logic [15:0] ra, rb;
        int sel, r;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy_v, 3'b000);
        check("rst_done", done_v, 3'b000);
        check("rst_y0", y0, Y_NONE);
        check("rst_y1", y1, Y_NONE);
        check("rst_y2", y2, Y_NONE);
        @(negedge clk) rst = 1'b0;

        do_cmp("t1_eq", 0, 16'h1234, 16'h1234, 1'b0);
        do_cmp("t2_uns", 0, 16'h8000, 16'h7FFF, 1'b0);
        do_cmp("t2_sgn", 0, 16'h8000, 16'h7FFF, 1'b1);
        do_cmp("t3_lt", 0, 16'h12F0, 16'h1300, 1'b0);
        do_cmp("t3_gt", 0, 16'hFFFF, 16'hFFFE, 1'b0);
        do_cmp("n1_gt", 1, 16'h0001, 16'h0000, 1'b0);
        do_cmp("n16_gt", 2, 16'h0001, 16'h0000, 1'b0);
        do_cmp("n16_sgn", 2, 16'hFFFF, 16'h0001, 1'b1);

        // Start held high: ignored while busy, accepted again on the done cycle.
        @(negedge clk);
        a = 16'h1234; b = 16'h1234; mode = 1'b0; start_v[0] = 1'b1;
        @(posedge clk);
        #1 a = 16'h8000; b = 16'h7FFF;
        check("b2b_busy0", busy_v[0], 1'b1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check("b2b_busy_mid", busy_v[0], 1'b1);
            check("b2b_nodone", done_v[0], 1'b0);
        end
        @(posedge clk);
        #1;
        check("b2b_done1", done_v[0], 1'b1);
        check("b2b_y1", y0, Y_EQ);
        check("b2b_idle1", busy_v[0], 1'b0);
        @(posedge clk);
        #1;
        check("b2b_rebusy", busy_v[0], 1'b1);
        check("b2b_pulse", done_v[0], 1'b0);
        start_v[0] = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_done2", done_v[0], 1'b1);
        check("b2b_y2", y0, Y_GT);

        // Abort an equal compare before it can finish.
        @(negedge clk);
        a = 16'hABCD; b = 16'hABCD; start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check("clr_busy", busy_v[0], 1'b0);
        check("clr_done", done_v[0], 1'b0);
        check("clr_y", y0, Y_GT);
        clr_v[0] = 1'b0;
        @(posedge clk);
        #1;
        check("clr_nodone", done_v[0], 1'b0);
        check("clr_idle", busy_v[0], 1'b0);

        @(negedge clk);
        a = 16'h0000; b = 16'h1111; start_v[0] = 1'b1; clr_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check("clrstart_busy", busy_v[0], 1'b0);
        start_v[0] = 1'b0; clr_v[0] = 1'b0;
        @(posedge clk);
        #1;
        check("clrstart_done", done_v[0], 1'b0);
        check("clrstart_y", y0, Y_GT);

        // Asynchronous reset mid-compare.
        @(negedge clk);
        a = 16'h5555; b = 16'h5555; start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_busy_pre", busy_v[0], 1'b1);
        rst = 1'b1;
        #1;
        check("rstmid_busy", busy_v[0], 1'b0);
        check("rstmid_done", done_v[0], 1'b0);
        check("rstmid_y", y0, Y_NONE);
        @(negedge clk) rst = 1'b0;
        do_cmp("post_rst", 0, 16'h00FF, 16'h0F00, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            sel = i % 3;
            ra = 16'($urandom);
            r = int'($urandom_range(0, 7));
            if (r == 0)      rb = ra;
            else if (r == 1) rb = ra ^ (16'h1 << $urandom_range(0, 15));
            else             rb = 16'($urandom);
            do_cmp("rand", sel, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
